// File: rtl/chess_eval_pkg.sv
// Shared board-evaluation definitions: square geometry, scan FSM states and
// the vertical mirror used to view the board from black's side.
package chess_eval_pkg;

    localparam int NUM_SQ = 64;
    localparam int SQ_W   = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        RESP = 2'd2
    } state_t;

    // Flip rank (a1 <-> a8); the file is unchanged.
    function automatic logic [SQ_W-1:0] mirror_sq(input logic [SQ_W-1:0] sq);
        return sq ^ SQ_W'(56);
    endfunction

endpackage

// File: rtl/pst_table_ram.sv
// Piece-square table storage: NUM_TABLES x 64 signed entries, one synchronous
// write port and 2*LANES asynchronous read ports that share one table select.
// A table select outside 0..NUM_TABLES-1 reads as zero on every port.
module pst_table_ram
    import chess_eval_pkg::*;
#(
    parameter int NUM_TABLES = 6,
    parameter int VAL_W      = 6,
    parameter int LANES      = 4,
    parameter int TBL_W      = 3
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [TBL_W-1:0]             wr_table,
    input  logic [SQ_W-1:0]              wr_sq,
    input  logic [VAL_W-1:0]             wr_data,
    input  logic [TBL_W-1:0]             rd_table,
    input  logic [LANES-1:0][SQ_W-1:0]   white_sq,
    input  logic [LANES-1:0][SQ_W-1:0]   black_sq,
    output logic [LANES-1:0][VAL_W-1:0]  white_val,
    output logic [LANES-1:0][VAL_W-1:0]  black_val
);

    // Storage only: contents are deliberately not reset so tuning survives rst_n.
    logic [VAL_W-1:0] mem [NUM_TABLES][NUM_SQ];

    logic wr_ok;
    logic rd_ok;

    assign wr_ok = (32'(wr_table) < 32'(NUM_TABLES));
    assign rd_ok = (32'(rd_table) < 32'(NUM_TABLES));

    // Commit a table entry; out-of-range table selects are ignored.
    always_ff @(posedge clk) begin
        if (we && wr_ok) begin
            mem[wr_table][wr_sq] <= wr_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_rd
            assign white_val[gi] = rd_ok ? mem[rd_table][white_sq[gi]] : '0;
            assign black_val[gi] = rd_ok ? mem[rd_table][black_sq[gi]] : '0;
        end
    endgenerate

endmodule

// File: rtl/pst_scan_eval.sv
// Sequential piece-square evaluator: scans LANES squares per cycle over a
// captured pair of occupancy bitboards and returns white minus black, with
// black squares looked up through the vertical mirror.
module pst_scan_eval
    import chess_eval_pkg::*;
#(
    parameter int NUM_TABLES = 6,
    parameter int VAL_W      = 6,
    parameter int LANES      = 4,
    parameter int SCORE_W    = 16,
    localparam int TBL_W     = (NUM_TABLES > 1) ? $clog2(NUM_TABLES) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_en,
    input  logic [TBL_W-1:0]          wr_table,
    input  logic [SQ_W-1:0]           wr_sq,
    input  logic signed [VAL_W-1:0]   wr_data,
    output logic                      wr_drop,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [TBL_W-1:0]          req_table,
    input  logic [NUM_SQ-1:0]         req_white_bb,
    input  logic [NUM_SQ-1:0]         req_black_bb,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic signed [SCORE_W-1:0] rsp_score,
    output logic                      busy
);

    localparam int NUM_GRP = NUM_SQ / LANES;
    localparam int GRP_W   = (NUM_GRP > 1) ? $clog2(NUM_GRP) : 1;

    state_t                      state_reg, state_next;
    logic [GRP_W-1:0]            grp_reg;
    logic [NUM_SQ-1:0]           white_reg;
    logic [NUM_SQ-1:0]           black_reg;
    logic [TBL_W-1:0]            table_reg;
    logic signed [SCORE_W-1:0]   acc_reg;
    logic signed [SCORE_W-1:0]   delta;
    logic                        tbl_we;
    logic                        accept;
    logic                        last_grp;

    logic [LANES-1:0][SQ_W-1:0]          white_sq;
    logic [LANES-1:0][SQ_W-1:0]          black_sq;
    logic [LANES-1:0][VAL_W-1:0]         white_val;
    logic [LANES-1:0][VAL_W-1:0]         black_val;
    logic signed [SCORE_W-1:0]           lane_term [LANES];

    assign accept   = req_valid && (state_reg == IDLE);
    assign last_grp = (grp_reg == GRP_W'(NUM_GRP - 1));

    pst_table_ram #(
        .NUM_TABLES (NUM_TABLES),
        .VAL_W      (VAL_W),
        .LANES      (LANES),
        .TBL_W      (TBL_W)
    ) u_ram (
        .clk       (clk),
        .we        (tbl_we),
        .wr_table  (wr_table),
        .wr_sq     (wr_sq),
        .wr_data   (wr_data),
        .rd_table  (table_reg),
        .white_sq  (white_sq),
        .black_sq  (black_sq),
        .white_val (white_val),
        .black_val (black_val)
    );

    // The captured bitboards shift down by LANES each scan cycle, so lane gi
    // always looks at bit gi while the square index comes from the group count.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [SCORE_W-1:0] w_ext;
            logic signed [SCORE_W-1:0] b_ext;
            assign white_sq[gi] = SQ_W'(int'(grp_reg) * LANES + gi);
            assign black_sq[gi] = mirror_sq(white_sq[gi]);
            assign w_ext = {{(SCORE_W-VAL_W){white_val[gi][VAL_W-1]}}, white_val[gi]};
            assign b_ext = {{(SCORE_W-VAL_W){black_val[gi][VAL_W-1]}}, black_val[gi]};
            assign lane_term[gi] = (white_reg[gi] ? w_ext : '0) - (black_reg[gi] ? b_ext : '0);
        end
    endgenerate

    // Adder tree: sum of the per-lane contributions for the current group.
    always_comb begin
        delta = '0;
        for (int l = 0; l < LANES; l++) begin
            delta = delta + lane_term[l];
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs; table writes only commit while idle.
    always_comb begin
        state_next = state_reg;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        tbl_we     = 1'b0;
        wr_drop    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                tbl_we    = wr_en;
                if (req_valid) begin
                    state_next = SCAN;
                end
            end
            SCAN: begin
                wr_drop = wr_en;
                if (last_grp) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                wr_drop   = wr_en;
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request capture, lane-group counter and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg   <= '0;
            grp_reg   <= '0;
            white_reg <= '0;
            black_reg <= '0;
            table_reg <= '0;
        end else if (accept) begin
            acc_reg   <= '0;
            grp_reg   <= '0;
            white_reg <= req_white_bb;
            black_reg <= req_black_bb;
            table_reg <= req_table;
        end else if (state_reg == SCAN) begin
            acc_reg   <= acc_reg + delta;
            grp_reg   <= grp_reg + GRP_W'(1);
            white_reg <= white_reg >> LANES;
            black_reg <= black_reg >> LANES;
        end
    end

    assign rsp_score = acc_reg;

endmodule

// File: tb/tb_pst_scan_eval.sv
// Directed bench for pst_scan_eval with hand-computed expected scores.
module tb_pst_scan_eval;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_table = '0;
    logic [5:0]  wr_sq = '0;
    logic signed [5:0] wr_data = '0;
    logic        wr_drop;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_table = '0;
    logic [63:0] req_white_bb = '0;
    logic [63:0] req_black_bb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic signed [15:0] rsp_score;
    logic        busy;

    int chk_cnt = 0;
    int pass_cnt = 0;

    pst_scan_eval #(
        .NUM_TABLES (6),
        .VAL_W      (6),
        .LANES      (4),
        .SCORE_W    (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_table     (wr_table),
        .wr_sq        (wr_sq),
        .wr_data      (wr_data),
        .wr_drop      (wr_drop),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_table    (req_table),
        .req_white_bb (req_white_bb),
        .req_black_bb (req_black_bb),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_score    (rsp_score),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        chk_cnt++;
        if (got == exp) begin
            pass_cnt++;
            $display("check %-14s got=%0d exp=%0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-14s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // All tasks start and end just after a falling edge.
    task automatic write_entry(input int t, input int sq, input int v);
        wr_en    = 1'b1;
        wr_table = 3'(t);
        wr_sq    = 6'(sq);
        wr_data  = 6'(v);
        @(posedge clk);
        @(negedge clk);
        wr_en    = 1'b0;
    endtask

    task automatic fill_table(input int t, input int v);
        for (int s = 0; s < 64; s++) begin
            write_entry(t, s, v);
        end
    endtask

    task automatic start_req(input int t, input logic [63:0] w, input logic [63:0] b);
        req_valid    = 1'b1;
        req_table    = 3'(t);
        req_white_bb = w;
        req_black_bb = b;
        @(posedge clk);
        @(negedge clk);
        req_valid    = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, output int lat);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) chk({tag, "_tmo"}, 0, 1);
    endtask

    task automatic finish_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic do_req(input string tag, input int t, input logic [63:0] w,
                          input logic [63:0] b, input int exp);
        int lat;
        start_req(t, w, b);
        chk({tag, "_busy"}, longint'(busy), 1);
        chk({tag, "_rdy0"}, longint'(req_ready), 0);
        wait_rsp(tag, lat);
        chk({tag, "_lat"}, lat, 16);
        chk({tag, "_score"}, longint'(rsp_score), exp);
        finish_rsp();
        chk({tag, "_rdy1"}, longint'(req_ready), 1);
    endtask

    localparam logic [63:0] BIT27 = 64'd1 << 27;
    localparam logic [63:0] BIT35 = 64'd1 << 35;
    localparam logic [63:0] ALL1  = '1;

    initial begin
        int lat;
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", longint'(req_ready), 1);
        chk("rst_valid", longint'(rsp_valid), 0);
        chk("rst_score", longint'(rsp_score), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_drop", longint'(wr_drop), 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Mirror basics: white 27 reads T1[27], black 27 reads T1[35].
        write_entry(1, 27, 10);
        write_entry(1, 35, -7);
        do_req("t1", 1, BIT27, BIT27, 17);
        do_req("t1_mir", 1, BIT35, BIT35, -17);

        fill_table(0, 5);
        do_req("t0_white", 0, ALL1, '0, 320);
        do_req("t0_black", 0, '0, ALL1, -320);

        fill_table(2, -32);
        do_req("t2_sext", 2, ALL1, '0, -2048);

        // Backpressure: hold the response, try a write that must be dropped.
        start_req(1, BIT27, BIT27);
        wait_rsp("hold", lat);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                wr_en = 1'b1; wr_table = 3'd1; wr_sq = 6'd27; wr_data = 6'sd31;
                #1;
                chk("hold_drop", longint'(wr_drop), 1);
            end
            @(posedge clk);
            @(negedge clk);
            wr_en = 1'b0;
            chk("hold_valid", longint'(rsp_valid), 1);
            chk("hold_score", longint'(rsp_score), 17);
            chk("hold_rdy", longint'(req_ready), 0);
        end
        #1;
        chk("drop_clear", longint'(wr_drop), 0);
        finish_rsp();
        do_req("readback", 1, BIT27, BIT27, 17);

        // Reset at scan cycle 8; tables must survive.
        start_req(1, BIT27, BIT27);
        repeat (7) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", longint'(rsp_valid), 0);
        chk("mrst_ready", longint'(req_ready), 1);
        chk("mrst_busy", longint'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_valid", longint'(rsp_valid), 0);
        chk("post_ready", longint'(req_ready), 1);
        do_req("rerun", 1, BIT27, BIT27, 17);

        // Out-of-range table reads as zero with normal timing.
        do_req("tbl7", 7, ALL1, ALL1, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/pst_scan_eval.md
# pst_scan_eval

Parametrised piece-square evaluator for the board evaluation path. It holds one writable signed positional table per piece type and accepts a request carrying the white and black occupancy bitboards for one piece type. It scans all 64 squares over several cycles and returns the signed sum (white minus black), mirroring squares vertically for black. It is the runtime-tunable, multi-table, sequential successor to the fixed single-table piece-square ROMs.

## Interface
Parameters:
- NUM_TABLES, 6, number of piece-type tables (pawn..king).
- VAL_W, 6, signed width of one table entry.
- LANES, 4, squares scanned per cycle; power of two, divides 64.
- SCORE_W, 16, signed result width; must be ≥ VAL_W+7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  table write strobe.
- wr_table  in  clog2(NUM_TABLES)  table select for write.
- wr_sq  in  6  square index 0..63 for write.
- wr_data  in  VAL_W  signed entry value.
- wr_drop  out  1  one-cycle pulse: write rejected (block not IDLE).
- req_valid  in  1  scan request.
- req_ready  out  1  block can accept a request.
- req_table  in  clog2(NUM_TABLES)  table to apply.
- req_white_bb  in  64  white occupancy; bit i = square i.
- req_black_bb  in  64  black occupancy.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_score  out  SCORE_W  signed score.
- busy  out  1  high in SCAN or RESP.

## Operation
- FSM states: IDLE, SCAN, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, capture both bitboards and req_table, clear the accumulator, clear the lane counter, and enter SCAN.
- SCAN: on each cycle, lane group g covers squares g*LANES..g*LANES+LANES-1.
  - Add sign-extended T[sq] for every set white bit.
  - Subtract T[sq^56] for every set black bit (vertical mirror).
  - After group 64/LANES-1, enter RESP.
- RESP: rsp_valid=1 and rsp_score holds the final sum. Both stay stable until rsp_ready; on that handshake, go to IDLE.
- Table writes are committed only in IDLE. If wr_en is asserted in SCAN or RESP, the write is dropped and wr_drop pulses for that cycle.
- req_table ≥ NUM_TABLES: every term reads as 0, so the result is 0. Normal timing applies.
- If the same square is set in both bitboards, both terms contribute. No legality checking.
- Arithmetic is signed and sign-extended to SCORE_W. No saturation is needed, because |score| ≤ 64·2^(VAL_W−1)·2 fits by the width rule.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_score=0, busy=0, wr_drop=0. FSM=IDLE, accumulator=0.
- Tables are storage, not reset. Contents survive rst_n. After power-up, tables are undefined until written.
- Write latency: an entry written at edge E is visible to a request accepted at edge E+1 or later.
- Latency: request accepted at edge E0. Accumulation occurs at edges E0+1..E0+64/LANES. rsp_valid is high in the cycle after edge E0+64/LANES (16 cycles for LANES=4).
- Simultaneous-request rule: req_ready=0 throughout SCAN and RESP. The earliest next accept is the edge after the rsp handshake, so requests cannot overlap.
- Reset asserted mid-SCAN or mid-RESP: the result is lost. The block is in IDLE with reset outputs immediately. Tables are intact.

## Structure
- Shared package chess_eval_pkg:
  - NUM_SQ=64 and SQ_W=6.
  - State enum {IDLE, SCAN, RESP}.
  - Function mirror_sq(sq)=sq^56.
- Sub-module pst_table_ram holds NUM_TABLES×64 entries of VAL_W bits. It has one synchronous write port and 2×LANES asynchronous read ports (white and mirrored black).
- Top level contains the FSM, lane counter, bitboard capture registers, and the adder tree plus accumulator.

## Test plan
- Write T1[27]=10 and T1[35]=−7. Request table 1 with white_bb=1<<27 and black_bb=1<<27. Expected: rsp_score=17, with rsp_valid 16 cycles after accept (LANES=4).
- Fill T0 with +5. Request with white_bb all ones and black_bb=0. Expected: 320. Swap the bitboards. Expected: −320.
- Fill T2 with −32. Request with white_bb all ones. Expected: −2048 (sign-extension check).
- Hold rsp_ready=0 for 5 cycles. Expected: rsp_valid and score stable, req_ready=0. A write issued during this window produces a wr_drop pulse, and a later read-back shows the table unchanged.
- Assert rst_n low at scan cycle 8. Expected: rsp_valid=0 and req_ready=1 after release. Re-running test 1 gives 17 without reloading tables.
- Request with req_table=7. Expected: rsp_score=0, with normal latency.
